int_sequencer: RTL and testbench
================================

# int_sequencer

Multi-cycle interrupt-entry controller for the 5-stage pipeline. On an external interrupt it freezes fetch, drains the in-flight instructions, pushes the return PC and flags onto the data stack, fetches the 32-bit handler address from the vector slot, and redirects fetch. It sits beside the fetch stage and drives the PC-load, stall/flush and the stack/memory port requests that the memory stage arbitrates.

## Interface
- AW, 20, data-memory address width
- VEC_ADDR, 2, word address of the vector high half; low half at VEC_ADDR+1
- DRAIN_CYC, 4, minimum drain cycles (EX, MEM and WB must retire)

- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- Int  in  1  external interrupt request, level input, edge-detected internally
- Busy  in  1  pipeline has a multi-cycle op in flight (load-use stall, ret/rti pop); blocks drain exit
- RtiDone  in  1  one-cycle pulse when an RTI retires; re-enables interrupts
- Pc  in  32  address of next instruction to fetch (return address)
- Flags  in  4  current CCR
- Sp  in  AW  current stack pointer; external SP decrements on the edge where SpDec=1
- MemRdData  in  16  data-memory read data, valid one cycle after MemRead
- Stall  out  1  freeze PC and IF/ID
- Flush  out  1  zero IF/ID on next edge
- MemWrite  out  1  push request
- MemRead  out  1  vector read request
- MemAddr  out  AW  address for MemWrite/MemRead
- MemWrData  out  16  push data
- SpDec  out  1  decrement SP by one word
- PcLoad  out  1  load PcNew into PC on next edge
- PcNew  out  32  handler address
- IntAck  out  1  one-cycle acknowledge, coincident with PcLoad

## Operation
- Edge detect: Int_q registered; `pending` set on edge where Int=1, Int_q=0. Set dominates clear in the same cycle.
- IntEn: reset 1; cleared on IDLE->DRAIN; set by RtiDone. RtiDone and IDLE->DRAIN in the same cycle: clear wins.
- FSM, one-hot or binary, Moore outputs decoded from state:
  - IDLE: all outputs 0. Go DRAIN when pending & IntEn.
  - DRAIN: Stall=1; counter loads DRAIN_CYC-1 on entry and decrements. Exit to PUSH_PCH when counter=0 & Busy=0. On exit, latch Pc→ret_pc and Flags→ret_flg, and clear pending.
  - PUSH_PCH: Stall, MemWrite, SpDec; MemAddr=Sp, MemWrData=ret_pc[31:16]. Go PUSH_PCL.
  - PUSH_PCL: same, with MemWrData=ret_pc[15:0]. Go PUSH_FLG.
  - PUSH_FLG: same, with MemWrData={12'b0,ret_flg}. Go RD_VH.
  - RD_VH: Stall, MemRead, MemAddr=VEC_ADDR. Go RD_VL.
  - RD_VL: Stall, MemRead, MemAddr=VEC_ADDR+1; capture MemRdData→PcNew[31:16]. Go LOAD.
  - LOAD: Stall, Flush, PcLoad, IntAck; PcNew[15:0] driven from MemRdData (combinational) and registered alongside. Go IDLE.
- Address arithmetic: VEC_ADDR+1 truncated to AW bits (wraps at 2^AW-1). Sp underflow is not checked; SP wraps.
- Int edges while IntEn=0 or mid-sequence: pending set and held; serviced after RtiDone. Multiple edges collapse to one.
- Busy held high: sequencer waits in DRAIN indefinitely with Stall=1.

## Timing
- Reset (Rst=0, async): state=IDLE, pending=0, Int_q=0, IntEn=1, counter=0, ret_pc=0, ret_flg=0, PcNew=0. All outputs 0.
- Latency, Busy=0, DRAIN_CYC=4. Int rises before edge E0, so pending=1 after E0. DRAIN occupies cycles 1-4, PUSH cycles 5-7, RD_VH 8, RD_VL 9, LOAD 10. IDLE at cycle 11. Stall is high for 10 cycles.
- Exactly 3 SpDec pulses per entry, on consecutive cycles. SP after entry = Sp0-3.
- Reset mid-sequence aborts immediately. Pushes already issued are not undone; no PcLoad is issued.
- Pc/Flags are sampled only on the DRAIN exit edge.

## Test plan
- Basic entry: Sp=0x00FFF; mem[2]=0x0000, mem[3]=0x0100; Pc=0x00000042, Flags=4'b1010; pulse Int → writes 0x0000@0xFFF, 0x0042@0xFFE, 0x000A@0xFFD. PcLoad+IntAck at cycle 10 with PcNew=0x00000100. Sp ends at 0xFFC.
- Busy extension: Busy=1 for cycles 1-7 → PUSH_PCH starts at cycle 8. Stall is continuous from cycle 1, and PcLoad lands at cycle 13.
- Masking: second Int edge during cycle 6 → no re-entry after LOAD. RtiDone at cycle 20 → DRAIN entered at cycle 21, and a second IntAck follows 10 cycles later.
- Level-high Int: Int held at 1 for 50 cycles, RtiDone pulsed at cycle 30 → exactly one IntAck. No re-trigger without a new rising edge.
- Async reset mid-push: Rst low at cycle 6 (between edges) → all outputs 0 immediately. After release, IntEn=1 and pending=0, and no PcLoad occurs.
- Vector wrap: AW=4, VEC_ADDR=15 → RD_VL reads address 0.

Source files
------------

// File: rtl/int_sequencer.sv
// Interrupt-entry sequencer: freezes fetch, drains the pipeline, pushes the return
// PC and flags, reads the 32-bit handler vector and redirects fetch.
module int_sequencer #(
  parameter int AW        = 20,
  parameter int VEC_ADDR  = 2,
  parameter int DRAIN_CYC = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Int,
  input  logic          Busy,
  input  logic          RtiDone,
  input  logic [31:0]   Pc,
  input  logic [3:0]    Flags,
  input  logic [AW-1:0] Sp,
  input  logic [15:0]   MemRdData,
  output logic          Stall,
  output logic          Flush,
  output logic          MemWrite,
  output logic          MemRead,
  output logic [AW-1:0] MemAddr,
  output logic [15:0]   MemWrData,
  output logic          SpDec,
  output logic          PcLoad,
  output logic [31:0]   PcNew,
  output logic          IntAck
);

  localparam int            CW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYC - 1);
  localparam logic [AW-1:0] VEC_HI   = AW'(VEC_ADDR);
  // The low-half vector address wraps within the AW-bit address space.
  localparam logic [AW-1:0] VEC_LO   = AW'(VEC_ADDR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_FLG,
    S_RD_VH,
    S_RD_VL,
    S_LOAD
  } state_e;

  state_e        state_q,   state_d;
  logic          int_q,     int_d;
  logic          pending_q, pending_d;
  logic          int_en_q,  int_en_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [31:0]   ret_pc_q,  ret_pc_d;
  logic [3:0]    ret_flg_q, ret_flg_d;
  logic [31:0]   pc_new_q,  pc_new_d;
  logic          enter_drain;
  logic          exit_drain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      int_q     <= 1'b0;
      pending_q <= 1'b0;
      int_en_q  <= 1'b1;
      cnt_q     <= '0;
      ret_pc_q  <= '0;
      ret_flg_q <= '0;
      pc_new_q  <= '0;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      pending_q <= pending_d;
      int_en_q  <= int_en_d;
      cnt_q     <= cnt_d;
      ret_pc_q  <= ret_pc_d;
      ret_flg_q <= ret_flg_d;
      pc_new_q  <= pc_new_d;
    end
  end

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    state_d     = state_q;
    int_d       = Int;
    pending_d   = pending_q;
    int_en_d    = int_en_q;
    cnt_d       = cnt_q;
    ret_pc_d    = ret_pc_q;
    ret_flg_d   = ret_flg_q;
    pc_new_d    = pc_new_q;
    enter_drain = 1'b0;
    exit_drain  = 1'b0;

    Stall     = 1'b0;
    Flush     = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    MemAddr   = '0;
    MemWrData = '0;
    SpDec     = 1'b0;
    PcLoad    = 1'b0;
    IntAck    = 1'b0;
    PcNew     = (state_q == S_IDLE) ? 32'h0 : pc_new_q;

    case (state_q)
      S_IDLE: begin
        if (pending_q && int_en_q) begin
          state_d     = S_DRAIN;
          cnt_d       = CNT_INIT;
          enter_drain = 1'b1;
        end
      end
      S_DRAIN: begin
        Stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!Busy) begin
          state_d    = S_PUSH_PCH;
          exit_drain = 1'b1;
          ret_pc_d   = Pc;
          ret_flg_d  = Flags;
        end
      end
      S_PUSH_PCH: begin
        Stall     = 1'b1;
        MemWrite  = 1'b1;
        SpDec     = 1'b1;
        MemAddr   = Sp;
        MemWrData = ret_pc_q[31:16];
        state_d   = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        Stall     = 1'b1;
        MemWrite  = 1'b1;
        SpDec     = 1'b1;
        MemAddr   = Sp;
        MemWrData = ret_pc_q[15:0];
        state_d   = S_PUSH_FLG;
      end
      S_PUSH_FLG: begin
        Stall     = 1'b1;
        MemWrite  = 1'b1;
        SpDec     = 1'b1;
        MemAddr   = Sp;
        MemWrData = {12'b0, ret_flg_q};
        state_d   = S_RD_VH;
      end
      S_RD_VH: begin
        Stall   = 1'b1;
        MemRead = 1'b1;
        MemAddr = VEC_HI;
        state_d = S_RD_VL;
      end
      S_RD_VL: begin
        // Read data for the high half arrives now, one cycle after its request.
        Stall           = 1'b1;
        MemRead         = 1'b1;
        MemAddr         = VEC_LO;
        pc_new_d[31:16] = MemRdData;
        state_d         = S_LOAD;
      end
      S_LOAD: begin
        Stall          = 1'b1;
        Flush          = 1'b1;
        PcLoad         = 1'b1;
        IntAck         = 1'b1;
        PcNew          = {pc_new_q[31:16], MemRdData};
        pc_new_d[15:0] = MemRdData;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh edge wins over the clear, so an edge on the exit cycle is not lost.
    if (Int && !int_q) begin
      pending_d = 1'b1;
    end else if (exit_drain) begin
      pending_d = 1'b0;
    end

    if (enter_drain) begin
      int_en_d = 1'b0;
    end else if (RtiDone) begin
      int_en_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: reset, entry timing, Busy extension, masking,
// level-held Int, asynchronous abort, and vector-address wrap on a narrow instance.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_i, busy, rti;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic [19:0] sp;
  logic [15:0] rd_data;
  logic        stall, flush, mem_write, mem_read, sp_dec, pc_load, int_ack;
  logic [19:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic [31:0] pc_new;
  logic [6:0]  ctl;

  logic        w_int;
  logic [3:0]  w_sp;
  logic [15:0] w_rd_data;
  logic        w_stall, w_flush, w_mem_write, w_mem_read, w_sp_dec, w_pc_load, w_int_ack;
  logic [3:0]  w_mem_addr;
  logic [15:0] w_mem_wr_data;
  logic [31:0] w_pc_new;

  int errors = 0;
  int checks = 0;

  // Environment: vector ROM, write log and SP counter driven from DUT requests.
  logic [15:0] vec_hi, vec_lo;
  logic [19:0] sp_base;
  int          dec_total = 0;
  int          dec_mark;
  int          wr_cnt = 0;
  int          wr_mark;
  logic [19:0] wa [0:63];
  logic [15:0] wd [0:63];

  assign sp  = sp_base - 20'(dec_total - dec_mark);
  assign ctl = {stall, flush, mem_write, mem_read, sp_dec, pc_load, int_ack};

  int_sequencer u_dut (
    .Clk(clk), .Rst(rst_n), .Int(int_i), .Busy(busy), .RtiDone(rti),
    .Pc(pc), .Flags(flags), .Sp(sp), .MemRdData(rd_data),
    .Stall(stall), .Flush(flush), .MemWrite(mem_write), .MemRead(mem_read),
    .MemAddr(mem_addr), .MemWrData(mem_wr_data), .SpDec(sp_dec),
    .PcLoad(pc_load), .PcNew(pc_new), .IntAck(int_ack)
  );

  int_sequencer #(.AW(4), .VEC_ADDR(15), .DRAIN_CYC(4)) u_wrap (
    .Clk(clk), .Rst(rst_n), .Int(w_int), .Busy(1'b0), .RtiDone(1'b0),
    .Pc(32'h0), .Flags(4'h0), .Sp(w_sp), .MemRdData(w_rd_data),
    .Stall(w_stall), .Flush(w_flush), .MemWrite(w_mem_write), .MemRead(w_mem_read),
    .MemAddr(w_mem_addr), .MemWrData(w_mem_wr_data), .SpDec(w_sp_dec),
    .PcLoad(w_pc_load), .PcNew(w_pc_new), .IntAck(w_int_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) rd_data <= (mem_addr == 20'd2) ? vec_hi : (mem_addr == 20'd3) ? vec_lo : 16'h0;
    if (w_mem_read) w_rd_data <= (w_mem_addr == 4'hF) ? 16'h0007 : (w_mem_addr == 4'h0) ? 16'hBEEF : 16'h0;
    if (sp_dec) dec_total <= dec_total + 1;
    if (mem_write && wr_cnt < 64) begin
      wa[wr_cnt] <= mem_addr;
      wd[wr_cnt] <= mem_wr_data;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at edge+6; the next rising edge is the first one out of reset.
  task automatic apply_reset(input logic [19:0] sp0);
    int_i = 1'b0; busy = 1'b0; rti = 1'b0; w_int = 1'b0;
    pc = 32'hDEAD_BEEF; flags = 4'b0101;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    sp_base  = sp0;
    dec_mark = dec_total;
    wr_mark  = wr_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; int_i = 1'b0; busy = 1'b0; rti = 1'b0; w_int = 1'b0;
    pc = 32'h0; flags = 4'h0; w_sp = 4'h0; sp_base = 20'h0; dec_mark = 0; wr_mark = 0;
    vec_hi = 16'h0; vec_lo = 16'h0;
    #3;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000000", ctl); end
    checks++; if (mem_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000", mem_addr); end
    checks++; if (mem_wr_data !== 16'h0) begin errors++; $display("FAIL reset_wrdata: got %h expected 0000", mem_wr_data); end
    checks++; if (pc_new !== 32'h0) begin errors++; $display("FAIL reset_pcnew: got %h expected 00000000", pc_new); end
    repeat (2) tick();
    #5;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_idle_ctl: got %b expected 0000000", ctl); end
  endtask

  task automatic test_basic();
    int stall_n, first_stall, last_stall, dec_n, first_dec, load_cyc, ack_cyc;
    logic [31:0] pcnew_seen;
    apply_reset(20'h00FFF);
    vec_hi = 16'h0000; vec_lo = 16'h0100;
    stall_n = 0; first_stall = -1; last_stall = -1; dec_n = 0; first_dec = -1;
    load_cyc = -1; ack_cyc = -1; pcnew_seen = 32'h0;
    int_i = 1'b1;
    tick();
    int_i = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      if (stall) begin stall_n++; if (first_stall < 0) first_stall = c; last_stall = c; end
      if (sp_dec) begin dec_n++; if (first_dec < 0) first_dec = c; end
      if (pc_load) begin load_cyc = c; pcnew_seen = pc_new; end
      if (int_ack) ack_cyc = c;
      // Only the value presented on the DRAIN exit edge may be captured.
      pc    = (c == 4) ? 32'h0000_0042 : 32'hDEAD_BEEF;
      flags = (c == 4) ? 4'b1010 : 4'b0101;
    end
    checks++; if (first_stall !== 1) begin errors++; $display("FAIL basic_first_stall: got %0d expected 1", first_stall); end
    checks++; if (last_stall !== 10) begin errors++; $display("FAIL basic_last_stall: got %0d expected 10", last_stall); end
    checks++; if (stall_n !== 10) begin errors++; $display("FAIL basic_stall_count: got %0d expected 10", stall_n); end
    checks++; if (first_dec !== 5) begin errors++; $display("FAIL basic_first_spdec: got %0d expected 5", first_dec); end
    checks++; if (dec_n !== 3) begin errors++; $display("FAIL basic_spdec_count: got %0d expected 3", dec_n); end
    checks++; if (load_cyc !== 10) begin errors++; $display("FAIL basic_pcload_cycle: got %0d expected 10", load_cyc); end
    checks++; if (ack_cyc !== 10) begin errors++; $display("FAIL basic_intack_cycle: got %0d expected 10", ack_cyc); end
    checks++; if (pcnew_seen !== 32'h0000_0100) begin errors++; $display("FAIL basic_pcnew: got %h expected 00000100", pcnew_seen); end
    checks++; if (wr_cnt - wr_mark !== 3) begin errors++; $display("FAIL basic_push_count: got %0d expected 3", wr_cnt - wr_mark); end
    checks++; if ({wa[wr_mark], wd[wr_mark]} !== {20'h00FFF, 16'h0000}) begin errors++; $display("FAIL basic_push_pch: got %h/%h expected 00fff/0000", wa[wr_mark], wd[wr_mark]); end
    checks++; if ({wa[wr_mark+1], wd[wr_mark+1]} !== {20'h00FFE, 16'h0042}) begin errors++; $display("FAIL basic_push_pcl: got %h/%h expected 00ffe/0042", wa[wr_mark+1], wd[wr_mark+1]); end
    checks++; if ({wa[wr_mark+2], wd[wr_mark+2]} !== {20'h00FFD, 16'h000A}) begin errors++; $display("FAIL basic_push_flg: got %h/%h expected 00ffd/000a", wa[wr_mark+2], wd[wr_mark+2]); end
    checks++; if (sp !== 20'h00FFC) begin errors++; $display("FAIL basic_sp_end: got %h expected 00ffc", sp); end
    checks++; if ({ctl, pc_new} !== 39'h0) begin errors++; $display("FAIL basic_idle_after: got %b/%h expected all zero", ctl, pc_new); end
  endtask

  task automatic test_busy();
    int stall_n, first_stall, last_stall, dec_n, first_dec, load_cyc;
    apply_reset(20'h00100);
    vec_hi = 16'h0000; vec_lo = 16'h0100;
    stall_n = 0; first_stall = -1; last_stall = -1; dec_n = 0; first_dec = -1; load_cyc = -1;
    int_i = 1'b1; busy = 1'b1;
    tick();
    int_i = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) tick();
      if (stall) begin stall_n++; if (first_stall < 0) first_stall = c; last_stall = c; end
      if (sp_dec) begin dec_n++; if (first_dec < 0) first_dec = c; end
      if (pc_load) load_cyc = c;
      busy = (c <= 6);
    end
    checks++; if (first_stall !== 1) begin errors++; $display("FAIL busy_first_stall: got %0d expected 1", first_stall); end
    checks++; if (last_stall !== 13 || stall_n !== 13) begin errors++; $display("FAIL busy_stall_span: got last=%0d count=%0d expected 13/13", last_stall, stall_n); end
    checks++; if (first_dec !== 8) begin errors++; $display("FAIL busy_push_start: got %0d expected 8", first_dec); end
    checks++; if (dec_n !== 3) begin errors++; $display("FAIL busy_spdec_count: got %0d expected 3", dec_n); end
    checks++; if (load_cyc !== 13) begin errors++; $display("FAIL busy_pcload_cycle: got %0d expected 13", load_cyc); end
    checks++; if (sp !== 20'h000FD) begin errors++; $display("FAIL busy_sp_end: got %h expected 000fd", sp); end
  endtask

  task automatic test_masking();
    int ack_n, ack0, ack1, re_entry, dec_n;
    logic [31:0] pcnew0;
    apply_reset(20'h00800);
    vec_hi = 16'h1234; vec_lo = 16'h5678;
    ack_n = 0; ack0 = -1; ack1 = -1; re_entry = -1; dec_n = 0; pcnew0 = 32'h0;
    int_i = 1'b1;
    tick();
    int_i = 1'b0;
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) tick();
      if (int_ack) begin
        if (ack_n == 0) begin ack0 = c; pcnew0 = pc_new; end
        else if (ack_n == 1) ack1 = c;
        ack_n++;
      end
      if (stall && c > 11 && re_entry < 0) re_entry = c;
      if (sp_dec) dec_n++;
      int_i = (c == 6);
      rti   = (c == 19);
    end
    checks++; if (ack_n !== 2) begin errors++; $display("FAIL mask_ack_count: got %0d expected 2", ack_n); end
    checks++; if (ack0 !== 10) begin errors++; $display("FAIL mask_first_ack: got %0d expected 10", ack0); end
    checks++; if (pcnew0 !== 32'h1234_5678) begin errors++; $display("FAIL mask_pcnew: got %h expected 12345678", pcnew0); end
    checks++; if (re_entry !== 21) begin errors++; $display("FAIL mask_reentry: got %0d expected 21", re_entry); end
    checks++; if (ack1 !== 30) begin errors++; $display("FAIL mask_second_ack: got %0d expected 30", ack1); end
    checks++; if (dec_n !== 6) begin errors++; $display("FAIL mask_spdec_count: got %0d expected 6", dec_n); end
  endtask

  task automatic test_level();
    int ack_n, ack0, dec_n;
    apply_reset(20'h00400);
    ack_n = 0; ack0 = -1; dec_n = 0;
    int_i = 1'b1;
    tick();
    for (int c = 0; c <= 59; c++) begin
      if (c > 0) tick();
      if (int_ack) begin if (ack_n == 0) ack0 = c; ack_n++; end
      if (sp_dec) dec_n++;
      int_i = (c < 49);
      rti   = (c == 29);
    end
    checks++; if (ack_n !== 1) begin errors++; $display("FAIL level_ack_count: got %0d expected 1", ack_n); end
    checks++; if (ack0 !== 10) begin errors++; $display("FAIL level_ack_cycle: got %0d expected 10", ack0); end
    checks++; if (dec_n !== 3) begin errors++; $display("FAIL level_spdec_count: got %0d expected 3", dec_n); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL level_idle_end: got %b expected 0", stall); end
  endtask

  task automatic test_reset_mid();
    int stall_n, load_n, first_stall, load_cyc;
    apply_reset(20'h00200);
    vec_hi = 16'h0000; vec_lo = 16'h0100;
    int_i = 1'b1;
    tick();
    int_i = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_in_push: got %b expected 1", mem_write); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL rstmid_ctl: got %b expected 0000000", ctl); end
    checks++; if ({mem_addr, mem_wr_data, pc_new} !== 68'h0) begin errors++; $display("FAIL rstmid_buses: got %h/%h/%h expected 0/0/0", mem_addr, mem_wr_data, pc_new); end
    #2;
    rst_n = 1'b1;
    checks++; if (wr_cnt - wr_mark !== 1) begin errors++; $display("FAIL rstmid_pushes_kept: got %0d expected 1", wr_cnt - wr_mark); end
    stall_n = 0; load_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (stall) stall_n++;
      if (pc_load) load_n++;
    end
    checks++; if (load_n !== 0) begin errors++; $display("FAIL rstmid_no_pcload: got %0d expected 0", load_n); end
    checks++; if (stall_n !== 0) begin errors++; $display("FAIL rstmid_pending_clear: got %0d expected 0", stall_n); end
    first_stall = -1; load_cyc = -1;
    int_i = 1'b1;
    tick();
    int_i = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (stall && first_stall < 0) first_stall = c;
      if (pc_load) load_cyc = c;
    end
    checks++; if (first_stall !== 1) begin errors++; $display("FAIL rstmid_inten_set: got %0d expected 1", first_stall); end
    checks++; if (load_cyc !== 10) begin errors++; $display("FAIL rstmid_reentry_load: got %0d expected 10", load_cyc); end
  endtask

  task automatic test_vec_wrap();
    logic [3:0]  addr8, addr9;
    logic [1:0]  rd89;
    logic [31:0] pcnew_seen;
    apply_reset(20'h0);
    w_sp = 4'h1;
    addr8 = 4'h5; addr9 = 4'h5; rd89 = 2'b00; pcnew_seen = 32'h0;
    w_int = 1'b1;
    tick();
    w_int = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) tick();
      if (c == 8) begin addr8 = w_mem_addr; rd89[1] = w_mem_read; end
      if (c == 9) begin addr9 = w_mem_addr; rd89[0] = w_mem_read; end
      if (w_pc_load) pcnew_seen = w_pc_new;
    end
    checks++; if (rd89 !== 2'b11) begin errors++; $display("FAIL wrap_reads: got %b expected 11", rd89); end
    checks++; if (addr8 !== 4'hF) begin errors++; $display("FAIL wrap_vh_addr: got %h expected f", addr8); end
    checks++; if (addr9 !== 4'h0) begin errors++; $display("FAIL wrap_vl_addr: got %h expected 0", addr9); end
    checks++; if (pcnew_seen !== 32'h0007_BEEF) begin errors++; $display("FAIL wrap_pcnew: got %h expected 0007beef", pcnew_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_masking();
    test_level();
    test_reset_mid();
    test_vec_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
